// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt controller. Prioritises the fault
// flags of the MEM instruction and the pending interrupts, issues a single
// atomic CP0 exception write, then flushes and redirects fetch to the handler
// (or to EPC on ERET) until fetch acknowledges.

typedef struct packed {
    logic        we;
    logic        bd;
    logic        exl;
    logic [4:0]  exc;
    logic [31:0] epc;
    logic [31:0] bva;
} reg_error;

module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        adel_if,
    input  logic        ri,
    input  logic        sys,
    input  logic        bp,
    input  logic        ov,
    input  logic        adel_ld,
    input  logic        ades,
    input  logic [31:0] mem_addr,
    input  logic        eret,
    input  logic [7:0]  intr_vect,
    input  logic [31:0] er_epc,
    output reg_error    cp0w,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack
);

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        IDLE,
        TRAP,
        VECTOR
    } state_e;

    state_e      state_q, state_d;
    reg_error    cp0w_q, cp0w_d;
    logic        flush_q, flush_d;
    logic        rv_q, rv_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] target_q, target_d;

    // Shadow copies of what was last written to CP0.
    logic        exl_s_q, exl_s_d;
    logic        bd_s_q, bd_s_d;
    logic [4:0]  exc_s_q, exc_s_d;
    logic [31:0] bva_s_q, bva_s_d;

    logic        ev_exc;
    logic        ev_eret;
    logic [4:0]  ev_code;
    logic [31:0] ev_bva;

    // Priority encoder: pick the highest-priority cause for the MEM instruction.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        ev_exc  = 1'b0;
        ev_eret = 1'b0;
        ev_code = EXC_INT;
        ev_bva  = bva_s_q;
        if (mem_valid) begin
            ev_exc = 1'b1;
            if ((intr_vect != 8'h00) && !exl_s_q) begin
                ev_code = EXC_INT;
            end else if (adel_if) begin
                ev_code = EXC_ADEL;
                ev_bva  = mem_pc;
            end else if (ri) begin
                ev_code = EXC_RI;
            end else if (sys) begin
                ev_code = EXC_SYS;
            end else if (bp) begin
                ev_code = EXC_BP;
            end else if (ov) begin
                ev_code = EXC_OV;
            end else if (adel_ld) begin
                ev_code = EXC_ADEL;
                ev_bva  = mem_addr;
            end else if (ades) begin
                ev_code = EXC_ADES;
                ev_bva  = mem_addr;
            end else begin
                ev_exc  = 1'b0;
                ev_eret = eret;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered so they take effect one cycle later.
    always_comb begin
        state_d  = state_q;
        cp0w_d   = '0;
        flush_d  = 1'b0;
        rv_d     = 1'b0;
        rpc_d    = '0;
        target_d = target_q;
        exl_s_d  = exl_s_q;
        bd_s_d   = bd_s_q;
        exc_s_d  = exc_s_q;
        bva_s_d  = bva_s_q;
        unique case (state_q)
            IDLE: begin
                if (ev_exc) begin
                    state_d     = TRAP;
                    cp0w_d.we   = 1'b1;
                    cp0w_d.exl  = 1'b1;
                    cp0w_d.exc  = ev_code;
                    cp0w_d.bva  = ev_bva;
                    if (exl_s_q) begin
                        // Nested: keep the original EPC/BD of the outer exception.
                        cp0w_d.epc = er_epc;
                        cp0w_d.bd  = bd_s_q;
                    end else begin
                        cp0w_d.epc = mem_bd ? (mem_pc - 32'd4) : mem_pc;
                        cp0w_d.bd  = mem_bd;
                    end
                    flush_d  = 1'b1;
                    target_d = EXC_VECTOR;
                    exl_s_d  = 1'b1;
                    bd_s_d   = cp0w_d.bd;
                    exc_s_d  = ev_code;
                    bva_s_d  = ev_bva;
                end else if (ev_eret) begin
                    state_d    = TRAP;
                    cp0w_d.we  = 1'b1;
                    cp0w_d.exl = 1'b0;
                    cp0w_d.epc = er_epc;
                    cp0w_d.exc = exc_s_q;
                    cp0w_d.bd  = bd_s_q;
                    cp0w_d.bva = bva_s_q;
                    flush_d    = 1'b1;
                    target_d   = er_epc;
                    exl_s_d    = 1'b0;
                end
            end
            TRAP: begin
                state_d = VECTOR;
                flush_d = 1'b1;
                rv_d    = 1'b1;
                rpc_d   = target_q;
            end
            VECTOR: begin
                if (redirect_ack) begin
                    state_d = IDLE;
                end else begin
                    flush_d = 1'b1;
                    rv_d    = 1'b1;
                    rpc_d   = target_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, registered outputs and shadows; asynchronous reset returns everything to idle/zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cp0w_q   <= '0;
            flush_q  <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            target_q <= '0;
            exl_s_q  <= 1'b0;
            bd_s_q   <= 1'b0;
            exc_s_q  <= '0;
            bva_s_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q  <= state_d;
            cp0w_q   <= cp0w_d;
            flush_q  <= flush_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
            target_q <= target_d;
            exl_s_q  <= exl_s_d;
            bd_s_q   <= bd_s_d;
            exc_s_q  <= exc_s_d;
            bva_s_q  <= bva_s_d;
        end
    end

    assign cp0w           = cp0w_q;
    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed literal checks plus randomized stimulus compared every
// cycle against a transaction-level reference model of the exception controller.

module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    typedef struct packed {
        logic        we;
        logic        bd;
        logic        exl;
        logic [4:0]  exc;
        logic [31:0] epc;
        logic [31:0] bva;
    } err_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid, mem_bd, adel_if, ri, sys, bp, ov, adel_ld, ades, eret;
    logic [31:0] mem_pc, mem_addr, er_epc;
    logic [7:0]  intr_vect;
    logic        redirect_ack;
    logic [71:0] cp0w_raw;
    err_t        cp0w_v;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;

    assign cp0w_v = cp0w_raw;

    exc_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd),
        .adel_if(adel_if), .ri(ri), .sys(sys), .bp(bp), .ov(ov),
        .adel_ld(adel_ld), .ades(ades), .mem_addr(mem_addr),
        .eret(eret), .intr_vect(intr_vect), .er_epc(er_epc),
        .cp0w(cp0w_raw), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ack(redirect_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Causes in priority order (index 0 highest) and their ExcCodes.
    function automatic logic [4:0] code_of(input int i);
        case (i)
            0:       return 5'd0;
            1, 6:    return 5'd4;
            2:       return 5'd10;
            3:       return 5'd8;
            4:       return 5'd9;
            5:       return 5'd12;
            default: return 5'd5;
        endcase
    endfunction

    // m_phase counts where we are in the event sequence: 0 none, 1 write cycle, 2 redirecting.
    int          m_phase;
    err_t        m_w;
    logic        m_exl, m_bd;
    logic [4:0]  m_exc;
    logic [31:0] m_bva, m_target;

    logic [7:0]  pri_flags;
    int          m_hit;
    err_t        m_exc_w, m_eret_w;

    assign pri_flags = {(intr_vect != 8'h00) && !m_exl, adel_if, ri, sys, bp, ov, adel_ld, ades};

    always_comb begin
        m_hit = -1;
        if (mem_valid) begin
            for (int i = 0; i < 8; i++) begin
                if (m_hit < 0 && pri_flags[7-i]) m_hit = i;
            end
        end
        m_exc_w     = '0;
        m_exc_w.we  = 1'b1;
        m_exc_w.exl = 1'b1;
        m_exc_w.exc = code_of(m_hit);
        m_exc_w.bva = (m_hit == 1) ? mem_pc : (m_hit >= 6) ? mem_addr : m_bva;
        if (m_exl) begin
            m_exc_w.epc = er_epc;
            m_exc_w.bd  = m_bd;
        end else begin
            m_exc_w.epc = mem_bd ? mem_pc - 32'd4 : mem_pc;
            m_exc_w.bd  = mem_bd;
        end
        m_eret_w = '{we: 1'b1, bd: m_bd, exl: 1'b0, exc: m_exc, epc: er_epc, bva: m_bva};
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase  <= 0;
            m_w      <= '0;
            m_exl    <= 1'b0;
            m_bd     <= 1'b0;
            m_exc    <= '0;
            m_bva    <= '0;
            m_target <= '0;
        end else begin
            case (m_phase)
                0: begin
                    if (m_hit >= 0) begin
                        m_w      <= m_exc_w;
                        m_exl    <= 1'b1;
                        m_bd     <= m_exc_w.bd;
                        m_exc    <= m_exc_w.exc;
                        m_bva    <= m_exc_w.bva;
                        m_target <= VEC;
                        m_phase  <= 1;
                    end else if (mem_valid && eret) begin
                        m_w      <= m_eret_w;
                        m_exl    <= 1'b0;
                        m_target <= er_epc;
                        m_phase  <= 1;
                    end
                end
                1:       m_phase <= 2;
                default: if (redirect_ack) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        case (m_phase)
            0: check("idle_outputs", {cp0w_raw, flush, redirect_valid, redirect_pc}, 128'h0);
            1: check("trap_outputs", {cp0w_raw, flush, redirect_valid}, {m_w, 1'b1, 1'b0});
            default: check("vector_outputs", {cp0w_v.we, flush, redirect_valid, redirect_pc},
                           {1'b0, 1'b1, 1'b1, m_target});
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        mem_valid = 0; mem_bd = 0; adel_if = 0; ri = 0; sys = 0; bp = 0; ov = 0;
        adel_ld = 0; ades = 0; eret = 0; intr_vect = 8'h00;
        mem_pc = 32'h0; mem_addr = 32'h0; er_epc = 32'h0; redirect_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From the TRAP cycle: enter VECTOR, acknowledge, land in IDLE.
    task automatic complete();
        tick();
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
    endtask

    task automatic do_eret(input logic [31:0] epc);
        mem_valid = 1; eret = 1; er_epc = epc;
        tick();
        idle_inputs();
        check("eret_we", cp0w_v.we, 1);
        check("eret_exl", cp0w_v.exl, 0);
        check("eret_epc", cp0w_v.epc, epc);
        tick();
        check("eret_redirect_pc", redirect_pc, epc);
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 0;
        repeat (3) tick();
        check("reset_outputs", {cp0w_raw, flush, redirect_valid, redirect_pc}, 128'h0);
        rst = 1;
        tick();

        // Load AdEL, full latency profile.
        mem_valid = 1; mem_pc = 32'h8000_0010; adel_ld = 1; mem_addr = 32'h0000_1003;
        tick();
        idle_inputs();
        check("t1_we", cp0w_v.we, 1);
        check("t1_exc", cp0w_v.exc, 4);
        check("t1_epc", cp0w_v.epc, 32'h8000_0010);
        check("t1_bva", cp0w_v.bva, 32'h0000_1003);
        check("t1_bd", cp0w_v.bd, 0);
        check("t1_exl", cp0w_v.exl, 1);
        check("t1_flush", flush, 1);
        tick();
        check("t1_rv", redirect_valid, 1);
        check("t1_rpc", redirect_pc, VEC);
        check("t1_we_vector", cp0w_v.we, 0);
        tick();
        tick();
        check("t1_rv_hold", redirect_valid, 1);
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        check("t1_rv_drop", redirect_valid, 0);
        check("t1_flush_drop", flush, 0);

        do_eret(32'h8000_0200);
        check("eret_clears_exl_shadow", m_exl, 0);

        // Overflow in a delay slot; BadVAddr untouched.
        mem_valid = 1; ov = 1; mem_bd = 1; mem_pc = 32'h8000_0104;
        tick();
        idle_inputs();
        check("t2_epc", cp0w_v.epc, 32'h8000_0100);
        check("t2_bd", cp0w_v.bd, 1);
        check("t2_exc", cp0w_v.exc, 12);
        check("t2_bva", cp0w_v.bva, 32'h0000_1003);
        complete();
        do_eret(32'h8000_0104);

        // EPC wraps modulo 2^32.
        mem_valid = 1; ri = 1; mem_bd = 1; mem_pc = 32'h0;
        tick();
        idle_inputs();
        check("wrap_epc", cp0w_v.epc, 32'hFFFF_FFFC);
        complete();
        do_eret(32'h0);

        // Interrupt beats RI and SYS.
        mem_valid = 1; intr_vect = 8'h04; ri = 1; sys = 1; mem_pc = 32'h8000_0400;
        tick();
        idle_inputs();
        check("t3_exc_int", cp0w_v.exc, 0);
        check("t3_epc", cp0w_v.epc, 32'h8000_0400);
        complete();
        // Nested: interrupt masked, RI wins, EPC kept.
        mem_valid = 1; intr_vect = 8'h04; ri = 1; sys = 1; mem_pc = 32'h8000_0480;
        er_epc = 32'h8000_0050;
        tick();
        idle_inputs();
        check("t3_nested_exc", cp0w_v.exc, 10);
        check("t3_nested_epc", cp0w_v.epc, 32'h8000_0050);
        check("t3_nested_bd", cp0w_v.bd, 0);
        complete();

        // ERET then an interrupt is accepted again.
        do_eret(32'h8000_0200);
        mem_valid = 1; intr_vect = 8'h01; mem_pc = 32'h8000_0500;
        tick();
        idle_inputs();
        check("t4_int_we", cp0w_v.we, 1);
        check("t4_int_exc", cp0w_v.exc, 0);
        check("t4_int_epc", cp0w_v.epc, 32'h8000_0500);
        tick();
        mem_valid = 1; ades = 1; mem_addr = 32'h0000_0002;
        tick();
        check("t5_ades_ignored_we", cp0w_v.we, 0);
        check("t5_still_vector", redirect_valid, 1);
        tick();
        check("t5_ades_ignored_we2", cp0w_v.we, 0);
        rst = 0;
        #1;
        check("t5_async_rv", redirect_valid, 0);
        check("t5_async_flush", flush, 0);
        check("t5_async_we", cp0w_v.we, 0);
        idle_inputs();
        tick();
        rst = 1;
        tick();

        // Interrupt waits for a valid instruction.
        intr_vect = 8'h80; mem_pc = 32'h8000_0300;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_wait_flush", flush, 0);
            check("t6_wait_we", cp0w_v.we, 0);
        end
        mem_valid = 1;
        tick();
        idle_inputs();
        check("t6_we", cp0w_v.we, 1);
        check("t6_exc", cp0w_v.exc, 0);
        check("t6_epc", cp0w_v.epc, 32'h8000_0300);
        complete();

        // Randomized traffic, model-checked every cycle.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst          = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            mem_valid    = ($urandom_range(0, 9) < 7);
            mem_bd       = ($urandom_range(0, 9) < 3);
            mem_pc       = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(0, 8)) : ($urandom & 32'hFFFF_FFFC);
            mem_addr     = $urandom;
            er_epc       = $urandom;
            adel_if      = ($urandom_range(0, 15) == 0);
            ri           = ($urandom_range(0, 15) == 0);
            sys          = ($urandom_range(0, 15) == 0);
            bp           = ($urandom_range(0, 15) == 0);
            ov           = ($urandom_range(0, 15) == 0);
            adel_ld      = ($urandom_range(0, 15) == 0);
            ades         = ($urandom_range(0, 15) == 0);
            eret         = ($urandom_range(0, 7) == 0);
            intr_vect    = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            redirect_ack = ($urandom_range(0, 9) < 4);
        end

        tick();
        rst = 1;
        idle_inputs();
        redirect_ack = 1;
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
